// File: rtl/ddr_cmd_pkg.sv
// DDR command encodings, mode-register fields and sequencer states
// shared by the init/refresh controller and its refresh timer.
package ddr_cmd_pkg;

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;
  localparam logic [2:0] CMD_MRS  = 3'b000;

  localparam logic [1:0] BA_MR  = 2'b00;
  localparam logic [1:0] BA_EMR = 2'b01;

  localparam int DLL_RST_BIT = 8;
  localparam int PRE_ALL_BIT = 10;

  localparam logic [2:0] PEND_MAX = 3'd7;

  typedef enum logic [3:0] {
    S_PWR,
    S_CKE_NOP,
    S_PRE1,
    S_EMRS,
    S_MRS_DLL,
    S_PRE2,
    S_AREF1,
    S_AREF2,
    S_MRS_FIN,
    S_IDLE,
    S_REF
  } state_t;

  function automatic logic [12:0] dll_reset_word(
    input logic [12:0] w
  );
    logic [12:0] r;
    r = w;
    r[DLL_RST_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ddr_ref_timer.sv
// Refresh interval counter with a saturating count of refreshes
// still owed to the DRAM and a sticky overrun flag.
module ddr_ref_timer
  import ddr_cmd_pkg::*;
#(
  parameter int unsigned T_REFI = 780,
  parameter int unsigned CNT_W  = 16
) (
  input  logic clk,
  input  logic enable,
  input  logic dec,
  input  logic clear,
  output logic pending_nz,
  output logic overrun
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(T_REFI - 1);

  logic [CNT_W-1:0] icnt;
  logic [2:0]       pend;
  logic             expire;
  logic             take;

  assign expire     = enable && (icnt == '0);
  assign take       = dec && (pend != 3'd0);
  assign pending_nz = (pend != 3'd0);

  always_ff @(posedge clk) begin
    if (clear) begin
      icnt    <= RELOAD;
      pend    <= 3'd0;
      overrun <= 1'b0;
    end else begin
      if (!enable || expire) begin
        icnt <= RELOAD;
      end else begin
        icnt <= icnt - CNT_W'(1);
      end
      // expiry and issue in one cycle cancel out
      if (expire && !take) begin
        if (pend == PEND_MAX) begin
          overrun <= 1'b1;
        end else begin
          pend <= pend + 3'd1;
        end
      end else if (take && !expire) begin
        pend <= pend - 3'd1;
      end
    end
  end

endmodule

// File: rtl/ddr_init_ref_ctrl.sv
// DDR power-up initialization sequencer and auto-refresh scheduler
// that owns the command pins until handing them to the command path.
module ddr_init_ref_ctrl
  import ddr_cmd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 20000,
  parameter int unsigned T_RP      = 3,
  parameter int unsigned T_MRD     = 2,
  parameter int unsigned T_RFC     = 8,
  parameter int unsigned T_DLL     = 200,
  parameter int unsigned T_REFI    = 780,
  parameter logic [12:0] MODE_WORD = 13'h021,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REF_ACK,
  output logic        CKE,
  output logic        RAS,
  output logic        CAS,
  output logic        WE,
  output logic [1:0]  BA,
  output logic [12:0] ADDR,
  output logic        INIT_DONE,
  output logic        REF_REQ,
  output logic        REF_BUSY,
  output logic        REF_OVERRUN
);

  localparam logic [CNT_W-1:0] L_PWR = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] L_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] L_MRD = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] L_RFC = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] L_DLL = CNT_W'(T_DLL - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             wait_done;
  logic             pending_nz;
  logic             fire;

  logic             cke_n;
  logic [2:0]       cmd_n;
  logic [1:0]       ba_n;
  logic [12:0]      addr_n;
  logic             done_n;
  logic             busy_n;

  assign wait_done = (cnt == '0);
  assign REF_REQ   = (state == S_IDLE) && pending_nz;
  assign fire      = REF_REQ && REF_ACK;

  ddr_ref_timer #(
    .T_REFI (T_REFI),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk        (CLK),
    .enable     (INIT_DONE),
    .dec        (fire),
    .clear      (RST),
    .pending_nz (pending_nz),
    .overrun    (REF_OVERRUN)
  );

  always_comb begin
    state_n = state;
    cnt_n   = wait_done ? cnt : cnt - CNT_W'(1);
    unique case (state)
      S_PWR: begin
        if (wait_done) begin
          state_n = S_CKE_NOP;
          cnt_n   = '0;
        end
      end
      S_CKE_NOP: begin
        state_n = S_PRE1;
        cnt_n   = L_RP;
      end
      S_PRE1: begin
        if (wait_done) begin
          state_n = S_EMRS;
          cnt_n   = L_MRD;
        end
      end
      S_EMRS: begin
        if (wait_done) begin
          state_n = S_MRS_DLL;
          cnt_n   = L_DLL;
        end
      end
      S_MRS_DLL: begin
        if (wait_done) begin
          state_n = S_PRE2;
          cnt_n   = L_RP;
        end
      end
      S_PRE2: begin
        if (wait_done) begin
          state_n = S_AREF1;
          cnt_n   = L_RFC;
        end
      end
      S_AREF1: begin
        if (wait_done) begin
          state_n = S_AREF2;
          cnt_n   = L_RFC;
        end
      end
      S_AREF2: begin
        if (wait_done) begin
          state_n = S_MRS_FIN;
          cnt_n   = L_MRD;
        end
      end
      S_MRS_FIN: begin
        if (wait_done) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      S_IDLE: begin
        if (fire) begin
          state_n = S_REF;
          cnt_n   = L_RFC;
        end
      end
      S_REF: begin
        if (wait_done) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_PWR;
        cnt_n   = L_PWR;
      end
    endcase
  end

  // a command is driven only in the first cycle of its state
  always_comb begin
    cke_n  = (state_n != S_PWR);
    cmd_n  = CMD_NOP;
    ba_n   = '0;
    addr_n = '0;
    done_n = INIT_DONE || (state_n == S_IDLE);
    busy_n = (state_n == S_REF);
    if (state_n != state) begin
      unique case (state_n)
        S_PRE1, S_PRE2: begin
          cmd_n = CMD_PRE;
          addr_n[PRE_ALL_BIT] = 1'b1;
        end
        S_EMRS: begin
          cmd_n = CMD_MRS;
          ba_n  = BA_EMR;
        end
        S_MRS_DLL: begin
          cmd_n  = CMD_MRS;
          ba_n   = BA_MR;
          addr_n = dll_reset_word(MODE_WORD);
        end
        S_MRS_FIN: begin
          cmd_n  = CMD_MRS;
          ba_n   = BA_MR;
          addr_n = MODE_WORD;
        end
        S_AREF1, S_AREF2, S_REF: begin
          cmd_n = CMD_AREF;
        end
        default: begin
          cmd_n = CMD_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= S_PWR;
      cnt            <= L_PWR;
      CKE            <= 1'b0;
      {RAS, CAS, WE} <= CMD_NOP;
      BA             <= '0;
      ADDR           <= '0;
      INIT_DONE      <= 1'b0;
      REF_BUSY       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      CKE            <= cke_n;
      {RAS, CAS, WE} <= cmd_n;
      BA             <= ba_n;
      ADDR           <= addr_n;
      INIT_DONE      <= done_n;
      REF_BUSY       <= busy_n;
    end
  end

endmodule

// File: tb/tb_ddr_init_ref_ctrl.sv
// Directed bench for the DDR init/refresh sequencer: init trace table,
// refresh cadence, saturation, same-cycle expiry and mid-run resets.
module tb_ddr_init_ref_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REF_ACK = 1'b0;
  logic        CKE;
  logic        RAS;
  logic        CAS;
  logic        WE;
  logic [1:0]  BA;
  logic [12:0] ADDR;
  logic        INIT_DONE;
  logic        REF_REQ;
  logic        REF_BUSY;
  logic        REF_OVERRUN;

  int errors = 0;
  int checks = 0;
  int gcyc   = 0;

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    int          gap;
  } init_vec_t;

  init_vec_t tbl [7];

  ddr_init_ref_ctrl #(
    .T_POWERUP (10),
    .T_RP      (3),
    .T_MRD     (2),
    .T_RFC     (8),
    .T_DLL     (20),
    .T_REFI    (50)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REF_ACK     (REF_ACK),
    .CKE         (CKE),
    .RAS         (RAS),
    .CAS         (CAS),
    .WE          (WE),
    .BA          (BA),
    .ADDR        (ADDR),
    .INIT_DONE   (INIT_DONE),
    .REF_REQ     (REF_REQ),
    .REF_BUSY    (REF_BUSY),
    .REF_OVERRUN (REF_OVERRUN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    gcyc++;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic is_aref();
    return {RAS, CAS, WE} == 3'b001;
  endfunction

  // reset, then walk the init trace; stop_at>0 aborts after that cycle
  task automatic run_init(input int stop_at, output int done);
    int ev;
    int cke_low;
    int quiet_bad;
    int exp_cyc;
    logic seen;
    ev = 0;
    cke_low = 0;
    quiet_bad = 0;
    exp_cyc = 12;
    seen = 1'b0;
    done = 0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_cke", CKE, 0);
    chk("rst_cmd", {RAS, CAS, WE}, 3'b111);
    chk("rst_ba", BA, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_flags", {INIT_DONE, REF_REQ, REF_BUSY, REF_OVERRUN}, 0);
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) tick();
      if (!CKE) cke_low++;
      if (REF_REQ || REF_BUSY) quiet_bad++;
      if ({RAS, CAS, WE} != 3'b111) begin
        if (ev < 7) begin
          chk($sformatf("init_cmd%0d", ev), {RAS, CAS, WE, BA, ADDR},
              {tbl[ev].cmd, tbl[ev].ba, tbl[ev].addr});
          chk($sformatf("init_cyc%0d", ev), c, exp_cyc);
          exp_cyc += tbl[ev].gap;
        end else begin
          chk("init_cmd_count", ev + 1, 7);
        end
        ev++;
      end
      if (INIT_DONE && !seen) begin
        seen = 1'b1;
        done = gcyc;
        chk("init_done_cyc", c, exp_cyc);
        break;
      end
      if (c == stop_at) break;
    end
    chk("cke_low", cke_low, 10);
    chk("init_quiet", quiet_bad, 0);
    if (stop_at == 0) begin
      chk("init_cmds", ev, 7);
      chk("init_done_seen", seen, 1);
    end
  endtask

  initial begin
    int d;
    int rel;
    int req_first;
    int busy_cnt;
    int busy_first;
    int busy_last;
    int ovr_first;
    int bad_cmd;
    int aref[$];

    tbl[0] = '{3'b010, 2'b00, 13'h400, 3};
    tbl[1] = '{3'b000, 2'b01, 13'h000, 2};
    tbl[2] = '{3'b000, 2'b00, 13'h121, 20};
    tbl[3] = '{3'b010, 2'b00, 13'h400, 3};
    tbl[4] = '{3'b001, 2'b00, 13'h000, 8};
    tbl[5] = '{3'b001, 2'b00, 13'h000, 8};
    tbl[6] = '{3'b000, 2'b00, 13'h021, 2};

    // reset in the middle of the DLL wait
    REF_ACK = 1'b0;
    run_init(25, d);
    chk("pre_rst_cke", CKE, 1);

    // ACK tied high, including through init
    REF_ACK = 1'b1;
    run_init(0, d);
    req_first = -1;
    busy_cnt = 0;
    busy_first = -1;
    busy_last = -1;
    aref.delete();
    for (int c = 1; c <= 120; c++) begin
      tick();
      rel = gcyc - d;
      if (REF_REQ && req_first < 0) req_first = rel;
      if (is_aref()) aref.push_back(rel);
      if (REF_BUSY && rel <= 70) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
    end
    chk("hi_req_first", req_first, 50);
    chk("hi_aref_n", aref.size(), 2);
    chk("hi_aref0", aref.size() > 0 ? aref[0] : -1, 51);
    chk("hi_period", aref.size() > 1 ? aref[1] - aref[0] : -1, 50);
    chk("hi_busy_first", busy_first, 51);
    chk("hi_busy_last", busy_last, 58);
    chk("hi_busy_cnt", busy_cnt, 8);
    for (int k = 0; k < 60 && !REF_BUSY; k++) tick();
    tick();
    tick();
    chk("hi_busy_before_rst", REF_BUSY, 1);

    // ACK held low long enough to saturate
    REF_ACK = 1'b0;
    run_init(0, d);
    ovr_first = -1;
    aref.delete();
    for (int c = 1; c <= 490; c++) begin
      tick();
      rel = gcyc - d;
      if (rel == 49) chk("sat_req49", REF_REQ, 0);
      if (rel == 50) chk("sat_req50", REF_REQ, 1);
      if (REF_OVERRUN && ovr_first < 0) ovr_first = rel;
      if (is_aref()) aref.push_back(rel);
      if (rel == 401) REF_ACK = 1'b1;
    end
    chk("sat_ovr_first", ovr_first, 400);
    chk("sat_aref_n", aref.size(), 8);
    chk("sat_aref0", aref.size() > 0 ? aref[0] : -1, 402);
    for (int i = 1; i < aref.size(); i++) begin
      chk($sformatf("sat_gap%0d", i), aref[i] - aref[i-1], 9);
    end
    chk("sat_ovr_sticky", REF_OVERRUN, 1);
    chk("sat_req_drained", REF_REQ, 0);
    for (int k = 0; k < 60 && !REF_BUSY; k++) tick();
    tick();
    tick();
    chk("sat_busy_before_rst", REF_BUSY, 1);

    // ACK while idle with no request, then same-cycle expiry and issue
    REF_ACK = 1'b0;
    run_init(0, d);
    req_first = -1;
    bad_cmd = 0;
    aref.delete();
    for (int c = 1; c <= 130; c++) begin
      tick();
      rel = gcyc - d;
      if (REF_REQ && req_first < 0) req_first = rel;
      if (rel < 50 && {RAS, CAS, WE} != 3'b111) bad_cmd++;
      if (is_aref()) aref.push_back(rel);
      if (rel == 99) chk("sc_req99", REF_REQ, 1);
      if (rel == 107) chk("sc_busy107", {REF_BUSY, REF_REQ}, 2'b10);
      if (rel == 108) chk("sc_req108", {REF_BUSY, REF_REQ}, 2'b01);
      if (rel == 119) chk("sc_req119", {REF_BUSY, REF_REQ}, 2'b00);
      REF_ACK = (rel >= 10 && rel <= 30) || rel == 99 || rel == 110;
    end
    chk("sc_nop_no_req", bad_cmd, 0);
    chk("sc_req_first", req_first, 50);
    chk("sc_aref_n", aref.size(), 2);
    chk("sc_aref0", aref.size() > 0 ? aref[0] : -1, 100);
    chk("sc_aref1", aref.size() > 1 ? aref[1] : -1, 111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
